// File: rtl/sign_extend_pipe.sv
// -----------------------------------------------------------------------------
// sign_extend_pipe
//
// Pipelined immediate/offset extension unit sitting between decode and
// execute. A narrow immediate field plus a 2-bit mode is turned into an
// OUT_W-bit operand, computed combinationally at the input and registered
// together with the entry that carries it.
//
// Modes (in_mode):
//   0 SEXT     : sign-extend in_data to OUT_W bits
//   1 ZEXT     : zero-extend in_data to OUT_W bits
//   2 SEXT_SHL : SEXT result shifted left by SHIFT (word-aligned offsets)
//   3 HIGH     : in_data placed in the top IN_W bits, low bits zero
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   flush      synchronous clear of both buffered entries (branch flush)
//   in_valid   in_data/in_mode carry an operand this cycle
//   in_ready   unit can accept an operand this cycle (registered)
//   in_data    raw immediate field, IN_W bits
//   in_mode    extension mode, see above
//   out_valid  out_data carries an operand
//   out_ready  consumer takes out_data this cycle
//   out_data   extended result, OUT_W bits
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on that side; valid/data are held stable by the producer until then,
// and ready never depends combinationally on valid. Storage is an output
// register plus one skid entry, giving 1-cycle latency, strict FIFO order and
// full throughput while out_ready stays high.
// -----------------------------------------------------------------------------
module sign_extend_pipe #(
    parameter int IN_W  = 22,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam logic [1:0] MODE_SEXT     = 2'd0;
    localparam logic [1:0] MODE_ZEXT     = 2'd1;
    localparam logic [1:0] MODE_SEXT_SHL = 2'd2;
    localparam logic [1:0] MODE_HIGH     = 2'd3;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] ext;

    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;

    logic in_xfer;
    logic out_free;
    logic out_from_skid;
    logic out_from_in;
    logic skid_load;
    logic out_valid_nxt;
    logic skid_valid_nxt;

    // Extension arithmetic. Shifts are by constants, so this is pure wiring
    // plus the sign-bit fan-out; IN_W+SHIFT <= OUT_W means SEXT_SHL never
    // drops significant bits.
    always_comb begin
        sext = OUT_W'($signed(in_data));
        zext = OUT_W'(in_data);
        ext  = sext;
        case (in_mode)
            MODE_SEXT:     ext = sext;
            MODE_ZEXT:     ext = zext;
            MODE_SEXT_SHL: ext = sext << SHIFT;
            MODE_HIGH:     ext = zext << (OUT_W - IN_W);
            default:       ext = sext;
        endcase
    end

    // Buffer control.
    always_comb begin
        in_xfer  = in_valid && in_ready;
        // The output register may take a new value when empty or draining.
        out_free = !out_valid || out_ready;
        // Older skid data always goes first to keep FIFO order.
        out_from_skid = out_free && skid_valid;
        out_from_in   = out_free && !skid_valid && in_xfer;
        // An accepted operand that cannot go straight to the output parks in
        // the skid entry. in_ready guarantees the entry is free (or being
        // vacated into the output) whenever this happens.
        skid_load      = in_xfer && !out_from_in;
        out_valid_nxt  = out_free ? (skid_valid || in_xfer) : 1'b1;
        skid_valid_nxt = skid_load || (skid_valid && !out_free);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else if (flush) begin
            // Flush wins over everything, including a concurrent input.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            out_valid  <= out_valid_nxt;
            skid_valid <= skid_valid_nxt;
            // Registered form of !skid_full: drops the cycle after the skid fills.
            in_ready   <= !skid_valid_nxt;
            if (out_from_skid) begin
                out_data <= skid_data;
            end else if (out_from_in) begin
                out_data <= ext;
            end
            if (skid_load) begin
                skid_data <= ext;
            end
        end
    end

endmodule

// File: doc/sign_extend_pipe.md
Name: sign_extend_pipe

Overview:
Parametrised, pipelined immediate/offset extension unit. It supersedes the fixed 18-bit and 22-bit combinational extenders and sits between decode and execute. It takes a narrow immediate field plus a mode and produces an OUT_W-bit operand. A valid/ready handshake with a two-entry skid buffer lets execute stall without dropping or duplicating operands.

Parameters:
IN_W, 22, width of the incoming immediate field; legal range 2..OUT_W-SHIFT.
OUT_W, 32, width of the extended result.
SHIFT, 2, left-shift amount applied in mode SEXT_SHL (word-aligned branch offsets); legal range 0..OUT_W-IN_W.

Ports:
clk  input  1  single system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous clear of all buffered entries (pipeline flush on branch).
in_valid  input  1  in_data/in_mode are valid this cycle.
in_ready  output  1  unit can accept an input this cycle; driven from a register.
in_data  input  IN_W  raw immediate field.
in_mode  input  2  0=SEXT, 1=ZEXT, 2=SEXT_SHL, 3=HIGH.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer accepts out_data this cycle.
out_data  output  OUT_W  extended result.

Behaviour:
- Arithmetic, computed combinationally at the input and registered with the entry:
  - SEXT: replicate in_data[IN_W-1] into bits OUT_W-1..IN_W.
  - ZEXT: zero-fill bits OUT_W-1..IN_W.
  - SEXT_SHL: SEXT result shifted left by SHIFT. Low SHIFT bits are 0. No bits are lost because IN_W+SHIFT <= OUT_W.
  - HIGH: in_data placed in bits OUT_W-1..OUT_W-IN_W; low OUT_W-IN_W bits are 0.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Storage is an output register plus one skid entry.
- Latency: 1 cycle. A transfer accepted at edge N is visible on out_data/out_valid after edge N.
- Output register:
  - Loads the new result when it is empty, or when it is being drained this cycle and the skid entry is empty.
  - If the skid entry is full and the output drains, the skid entry moves into the output register. The new input, if any, goes to the skid entry.
- Skid entry:
  - Filled when an input arrives while the output register is full and not draining.
  - in_ready = !skid_full (registered). in_ready drops the cycle after the skid entry fills.
  - A transfer presented while in_ready=1 is never lost.
- Ordering: strict FIFO. No reordering, duplication or drop.
- Throughput: 1 transfer per cycle when out_ready is held high.
- out_data while out_valid=0: holds its last value. Benches must not check it.
- flush:
  - On the edge where flush=1, both entries are invalidated and in_ready=1 after the edge.
  - An input transfer presented in the same cycle as flush is discarded.
  - flush has priority over all other updates.
- rst (async):
  - out_valid=0, in_ready=0 while rst is asserted, out_data=0, skid entry empty.
  - in_ready=1 from the first clk edge after rst deasserts.
  - Reset mid-operation discards all buffered data.
- Simultaneous input and output transfer:
  - Skid empty: the output register reloads with the new result; out_valid stays 1.
  - Skid full: skid moves to the output and the new input goes to the skid entry. This case arises only if in_ready was 1 that cycle.

Test Plan:
- Defaults, mode SEXT, out_ready=1: in_data 0x200000 -> out_data 0xFFE00000 one cycle later; in_data 0x1FFFFF -> 0x001FFFFF.
- Mode ZEXT with 0x3FFFFF -> 0x003FFFFF. Mode SEXT_SHL: 0x3FFFFF -> 0xFFFFFFFC and 0x000001 -> 0x00000004. Mode HIGH with 0x00ABCD -> 0x02AF3400.
- Backpressure:
  - Hold out_ready=0 and present A=1, B=2, C=3 back-to-back in SEXT.
  - A and B are accepted; in_ready=0 after B's edge; C is held.
  - Raise out_ready: outputs are 0x1, 0x2, 0x3 in order, each exactly once.
- Streaming: i=0..255 presented every cycle in all four modes with out_ready=1 -> out_valid continuous after 1 cycle; every result matches the reference model; in_ready never drops.
- Flush with both entries full plus a concurrent input -> out_valid=0 and in_ready=1 next cycle; the discarded values never appear.
- Assert rst asynchronously mid-stream, between clock edges -> out_valid and in_ready go 0 immediately. After release, the first new input appears 1 cycle after acceptance.
